// File: rtl/nor_resp_checker_pkg.sv
// Shared types, default sizes and the NOR reference model for the gate checker.
package gate_chk_pkg;

  localparam int unsigned N_IN_DEF    = 3;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned MAX_VEC_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Callers zero-extend the vector, so one function serves any N_IN up to 32.
  function automatic logic nor_ref(input logic [31:0] vec);
    return ~|vec;
  endfunction

endpackage

// File: rtl/nor_resp_checker_if.sv
// Sample handshake between the gate-response source and the checker.
interface nor_resp_checker_if #(
  parameter int unsigned N_IN = gate_chk_pkg::N_IN_DEF
) ();
  logic            in_valid;
  logic [N_IN-1:0] in_vec;
  logic            in_y;
  logic            in_ready;

  modport master (output in_valid, output in_vec, output in_y, input in_ready);
  modport slave  (input in_valid, input in_vec, input in_y, output in_ready);
endinterface

// File: rtl/nor_resp_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_inc
);

  // count_inc is the would-be value after one increment, independent of inc.
  assign count_inc = (&count) ? count : count + W'(1);

  // Clear wins over increment; saturation is folded into count_inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/nor_resp_checker.sv
// Response checker for a NOR gate: compares samples against nor_ref,
// tracks coverage and error statistics, and reports done/pass.
module nor_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MAX_VEC = MAX_VEC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  nor_resp_checker_if.slave    bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     vec_cnt,
  output logic [2**N_IN-1:0]   cov_map,
  output logic                 first_fail_valid,
  output logic [N_IN-1:0]      first_fail_vec
);

  localparam int unsigned COV_W = 2**N_IN;

  state_t           state, state_next;
  logic             clr, accept, mismatch, finish;
  logic [COV_W-1:0] cov_post;
  logic [CNT_W-1:0] err_inc, vec_inc;

  // in_ready/busy/done decode straight from the state register, so they are registered.
  assign bus.in_ready = (state == ST_RUN);
  assign busy         = (state == ST_RUN);
  assign done         = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state, accept qualification and run-exit detection on post-update values.
  always_comb begin
    state_next = state;
    clr        = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    mismatch   = (bus.in_y != nor_ref(32'(bus.in_vec)));
    cov_post   = cov_map | (COV_W'(1) << bus.in_vec);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr        = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start) begin
          clr = 1'b1;
        end else if (bus.in_valid) begin
          accept = 1'b1;
          if ((&cov_post) || (vec_inc == CNT_W'(MAX_VEC))) begin
            finish     = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc       (accept & mismatch),
    .count     (err_cnt),
    .count_inc (err_inc)
  );

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc       (accept),
    .count     (vec_cnt),
    .count_inc (vec_inc)
  );

  // Coverage, first-failure capture and the pass verdict.
  // A saturating err_cnt never returns to zero, so "post-update err_cnt == 0"
  // reduces to "err_cnt == 0 and this sample matched".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cov_map          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      pass             <= 1'b0;
    end else if (clr) begin
      cov_map          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      pass             <= 1'b0;
    end else begin
      if (accept) cov_map <= cov_post;
      if (accept && mismatch && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_vec   <= bus.in_vec;
      end
      if (finish) pass <= (&cov_post) && (err_cnt == '0) && !mismatch;
    end
  end

  logic unused_err_inc;
  assign unused_err_inc = ^err_inc;

endmodule

// File: tb/tb_nor_resp_checker.sv
// Directed bench for nor_resp_checker with a per-cycle statistics model.
module tb_nor_resp_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, pass, first_fail_valid;
  logic [7:0] err_cnt, vec_cnt, cov_map;
  logic [2:0] first_fail_vec;

  int n_vec  = 0;
  int n_miss = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  nor_resp_checker_if #(.N_IN(3)) bus ();

  nor_resp_checker #(.N_IN(3), .CNT_W(8), .MAX_VEC(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_cnt          (err_cnt),
    .vec_cnt          (vec_cnt),
    .cov_map          (cov_map),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: run statistics kept as plain integers and a coverage bit set.
  bit m_run, m_done, m_pass, m_ffv;
  int m_vc, m_ec, m_ffvec, m_v;
  bit [7:0] m_cov;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_done = 0; m_pass = 0; m_ffv = 0;
      m_vc = 0; m_ec = 0; m_ffvec = 0; m_cov = '0;
    end else if (start) begin
      m_run = 1; m_done = 0; m_pass = 0; m_ffv = 0;
      m_vc = 0; m_ec = 0; m_ffvec = 0; m_cov = '0;
    end else if (m_run && bus.in_valid) begin
      m_v = int'(bus.in_vec);
      if (m_vc < 255) m_vc++;
      m_cov[m_v] = 1'b1;
      if (bus.in_y != (m_v == 0)) begin
        if (m_ec < 255) m_ec++;
        if (!m_ffv) begin
          m_ffv = 1;
          m_ffvec = m_v;
        end
      end
      if (m_cov == 8'hFF || m_vc == 32) begin
        m_run  = 0;
        m_done = 1;
        m_pass = (m_cov == 8'hFF) && (m_ec == 0);
      end
    end
  end

  // Compare every output against the model each cycle, away from the rising edge.
  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("in_ready", int'(bus.in_ready), int'(m_run));
      chk("busy", int'(busy), int'(m_run));
      chk("done", int'(done), int'(m_done));
      chk("pass", int'(pass), int'(m_pass));
      chk("err_cnt", int'(err_cnt), m_ec);
      chk("vec_cnt", int'(vec_cnt), m_vc);
      chk("cov_map", int'(cov_map), int'(m_cov));
      chk("ff_valid", int'(first_fail_valid), int'(m_ffv));
      if (m_ffv) chk("ff_vec", int'(first_fail_vec), m_ffvec);
    end
  end

  task automatic drv(input bit s, input bit v, input int vec, input bit y);
    start        = s;
    bus.in_valid = v;
    bus.in_vec   = 3'(vec);
    bus.in_y     = y;
    @(negedge clk);
  endtask

  task automatic sweep(input int bad);
    for (int i = 0; i < 8; i++) drv(0, 1, i, (i == 0) ^ (i == bad));
  endtask

  int rep_list[9] = '{0, 1, 2, 3, 3, 4, 5, 6, 7};

  initial begin
    rst = 1'b1; start = 0; bus.in_valid = 0; bus.in_vec = '0; bus.in_y = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_vec_cnt", int'(vec_cnt), 0);
    rst = 1'b0;
    checking = 1'b1;

    // Exhaustive correct sweep.
    drv(1, 0, 0, 0);
    chk("s1_ready", int'(bus.in_ready), 1);
    sweep(-1);
    chk("s1_done", int'(done), 1);
    chk("s1_pass", int'(pass), 1);
    chk("s1_err", int'(err_cnt), 0);
    chk("s1_vec", int'(vec_cnt), 8);
    chk("s1_cov", int'(cov_map), 'hFF);
    chk("s1_ffv", int'(first_fail_valid), 0);
    drv(0, 1, 5, 1);
    drv(0, 1, 0, 0);
    chk("s1_hold_vec", int'(vec_cnt), 8);
    chk("s1_hold_done", int'(done), 1);

    // Faulty gate on vector 101.
    drv(1, 0, 0, 0);
    sweep(5);
    chk("s2_done", int'(done), 1);
    chk("s2_pass", int'(pass), 0);
    chk("s2_err", int'(err_cnt), 1);
    chk("s2_ffv", int'(first_fail_valid), 1);
    chk("s2_ffvec", int'(first_fail_vec), 5);

    // Timeout: 32 copies of 000.
    drv(1, 0, 0, 0);
    for (int i = 0; i < 31; i++) drv(0, 1, 0, 1);
    chk("s3_not_done", int'(done), 0);
    drv(0, 1, 0, 1);
    chk("s3_done", int'(done), 1);
    chk("s3_pass", int'(pass), 0);
    chk("s3_vec", int'(vec_cnt), 32);
    chk("s3_cov", int'(cov_map), 'h01);
    chk("s3_err", int'(err_cnt), 0);

    // Gapped handshake with a repeated 011; gap cycles carry a bad sample.
    drv(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drv(0, 1, rep_list[i], rep_list[i] == 0);
      drv(0, 0, 7, 1);
    end
    chk("s4_vec", int'(vec_cnt), 9);
    chk("s4_cov", int'(cov_map), 'hFF);
    chk("s4_pass", int'(pass), 1);
    chk("s4_err", int'(err_cnt), 0);

    // Restart mid-run; the sample presented with start is dropped.
    drv(1, 0, 0, 0);
    drv(0, 1, 0, 1);
    drv(0, 1, 1, 1);
    drv(0, 1, 2, 0);
    drv(0, 1, 3, 0);
    chk("s5_mid_vec", int'(vec_cnt), 4);
    chk("s5_mid_err", int'(err_cnt), 1);
    drv(1, 1, 2, 1);
    chk("s5_clr_vec", int'(vec_cnt), 0);
    chk("s5_clr_err", int'(err_cnt), 0);
    chk("s5_clr_ffv", int'(first_fail_valid), 0);
    chk("s5_busy", int'(busy), 1);
    sweep(-1);
    chk("s5_vec", int'(vec_cnt), 8);
    chk("s5_pass", int'(pass), 1);

    // Asynchronous reset between clock edges in the middle of a run.
    drv(1, 0, 0, 0);
    drv(0, 1, 0, 1);
    drv(0, 1, 1, 0);
    drv(0, 1, 2, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_ready", int'(bus.in_ready), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_pass", int'(pass), 0);
    chk("ar_vec", int'(vec_cnt), 0);
    chk("ar_err", int'(err_cnt), 0);
    chk("ar_cov", int'(cov_map), 0);
    chk("ar_ffv", int'(first_fail_valid), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    drv(0, 1, 0, 1);
    drv(0, 1, 4, 1);
    drv(0, 1, 7, 0);
    chk("ar_idle_vec", int'(vec_cnt), 0);
    chk("ar_idle_busy", int'(busy), 0);
    chk("ar_idle_err", int'(err_cnt), 0);
    drv(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/nor_resp_checker.md
Name: nor_resp_checker

Overview:
- Self-checking response side of the 3-input NOR gate bench.
- Accepts (input vector, DUT output) samples over a valid/ready handshake and compares each against a NOR reference model.
- Tracks exhaustive-vector coverage and mismatch statistics, then reports done/pass.
- The stimulus side drives vectors into the gate; this block consumes the vector plus the gate's response.

Parameters:
- N_IN, 3, number of gate inputs (vector width).
- CNT_W, 8, width of the sample and error counters.
- MAX_VEC, 32, number of accepted samples after which a run ends without full coverage (timeout).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; clears statistics and begins a run.
- in_valid  input  1  sample present on in_vec/in_y.
- in_vec  input  N_IN  gate input vector {a,b,c}, MSB = a.
- in_y  input  1  DUT output for in_vec.
- in_ready  output  1  checker accepts a sample this cycle.
- busy  output  1  run in progress.
- done  output  1  run finished; held until next start.
- pass  output  1  valid when done; 1 = full coverage and zero errors.
- err_cnt  output  CNT_W  mismatch count, saturating.
- vec_cnt  output  CNT_W  accepted sample count, saturating.
- cov_map  output  2**N_IN  bit i set once vector value i has been accepted.
- first_fail_valid  output  1  at least one mismatch recorded.
- first_fail_vec  output  N_IN  in_vec of the first mismatching sample.

Behaviour:
- Reset value of every output is 0: busy, done, pass, err_cnt, vec_cnt, cov_map, first_fail_*, in_ready. FSM returns to IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - start moves to RUN next cycle, clearing err_cnt, vec_cnt, cov_map and first_fail_*.
- RUN:
  - busy=1 and in_ready=1 (registered, asserted from the first RUN cycle).
  - Accept occurs when in_valid & in_ready.
  - expected = ~|in_vec; a mismatch is in_y != expected.
  - On each accept, updates are registered and visible the next cycle:
    - vec_cnt+1, saturating at all-ones.
    - cov_map[in_vec] set.
    - On mismatch, err_cnt+1 (saturating). If first_fail_valid was 0, capture in_vec and set first_fail_valid.
  - Exit when the post-update cov_map is all ones, or when the post-update vec_cnt equals MAX_VEC. Both are evaluated on the same accept.
  - On exit: go to DONE; done=1, busy=0, in_ready=0.
  - pass = full coverage & (post-update err_cnt == 0).
  - Coverage completion takes priority over the MAX_VEC timeout when both occur on the same sample.
  - A mismatch on the completing sample yields pass=0.
- DONE:
  - Outputs are held; in_valid is ignored.
  - start clears the statistics and done/pass, then enters RUN.
- start during RUN: restarts. Statistics clear and the in-flight sample in that cycle is discarded; state stays RUN.
- Repeated vectors are legal: they count in vec_cnt and are checked, but do not change cov_map.
- in_valid with in_ready=0 is ignored; no buffering.
- Asynchronous rst at any time, including mid-run, immediately clears all state and outputs.

Decomposition:
- Shared package (gate_chk_pkg) holds:
  - FSM state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
  - Default N_IN/CNT_W/MAX_VEC constants.
  - Reference function nor_ref(vec) returning ~|vec.
- One natural sub-module: sat_counter (width-parameterised, with clear/increment and saturation), instantiated for err_cnt and vec_cnt.

Test Plan:
- Exhaustive pass: start, then feed vectors 000..111 with correct y (1 for 000, else 0), back-to-back valid. Required: done=1 the cycle after the 8th accept; pass=1, err_cnt=0, vec_cnt=8, cov_map=8'hFF, first_fail_valid=0.
- Faulty DUT: same sequence but y=1 for vector 101. Required: done after 8th accept, pass=0, err_cnt=1, first_fail_valid=1, first_fail_vec=3'b101.
- Timeout: feed 000 with y=1 repeatedly, 32 times. Required: done on 32nd accept, pass=0, vec_cnt=32, cov_map=8'h01, err_cnt=0.
- Gapped handshake and repeats: valid toggles 1/0 and vector 011 is sent twice among a full sweep. Required: vec_cnt=9, cov_map=8'hFF, pass=1, no accepts while in_valid=0.
- Restart and reset: start, 4 samples, then start again, followed by a full correct sweep. Required: vec_cnt=8, pass=1. Separately, assert rst mid-run (between clock edges). Required: all outputs 0 immediately, FSM in IDLE, in_valid ignored until the next start.
